// File: rtl/control_sequencer.sv
// Instruction control sequencer: fetch, execute, load/store wait and trap FSM.
// Tracks a bounded wait counter, a sticky trap cause and a retired count.
module control_sequencer #(
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               halt,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_segv,
    input  logic               data_segv,
    input  logic               wait_instr,
    input  logic               wait_data,
    input  logic               ld_req,
    input  logic               st_req,
    input  logic               instr_pc,
    input  logic               invalid_instruction,
    output logic [INSTR_W-1:0] instr_q,
    output logic [2:0]         state,
    output logic               pc_inc,
    output logic               reg_write,
    output logic               ld,
    output logic               st,
    output logic               trap,
    output logic [2:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_HALT       = 3'd0,
        S_FETCH      = 3'd1,
        S_DO         = 3'd2,
        S_WAIT_LOAD  = 3'd3,
        S_WAIT_STORE = 3'd4,
        S_TRAP       = 3'd5
    } state_t;

    localparam logic [2:0] C_ISEGV   = 3'd1;
    localparam logic [2:0] C_DSEGV   = 3'd2;
    localparam logic [2:0] C_ILLEGAL = 3'd3;
    localparam logic [2:0] C_TIMEOUT = 3'd4;

    // Wide enough to hold TIMEOUT; wraps harmlessly when the timeout is disabled.
    localparam int WCNT_W = $clog2(TIMEOUT + 2);

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_word_q, instr_word_d;
    logic [2:0]          cause_q, cause_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                pc_q, pc_d;
    logic                ld_q, ld_d;
    logic                st_q, st_d;
    logic                waiting;
    logic                fetch_done;
    logic                timeout_hit;

    // The current wait cycle is the TIMEOUT-th one spent waiting in this phase.
    assign timeout_hit = (TIMEOUT > 0) && ((int'(wait_cnt_q) + 1) >= TIMEOUT);

    // Next-state, trap cause, decode capture and counter updates.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        instr_word_d = instr_word_q;
        retired_d    = retired_q;
        pc_d         = pc_q;
        ld_d         = ld_q;
        st_d         = st_q;
        waiting      = 1'b0;
        fetch_done   = 1'b0;
        wait_cnt_d   = wait_cnt_q;

        unique case (state_q)
            S_HALT: begin
                if (go && !halt) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (instr_segv) begin
                    state_d = S_TRAP;
                    cause_d = C_ISEGV;
                end else if (wait_instr) begin
                    waiting = 1'b1;
                    if (timeout_hit) begin
                        state_d = S_TRAP;
                        cause_d = C_TIMEOUT;
                    end
                end else begin
                    fetch_done = 1'b1;
                    if (invalid_instruction || (ld_req && st_req)) begin
                        state_d = S_TRAP;
                        cause_d = C_ILLEGAL;
                    end else if (ld_req) begin
                        state_d = S_WAIT_LOAD;
                    end else if (st_req) begin
                        state_d = S_WAIT_STORE;
                    end else begin
                        state_d = S_DO;
                    end
                end
            end
            S_WAIT_LOAD, S_WAIT_STORE: begin
                if (data_segv) begin
                    state_d = S_TRAP;
                    cause_d = C_DSEGV;
                end else if (wait_data) begin
                    waiting = 1'b1;
                    if (timeout_hit) begin
                        state_d = S_TRAP;
                        cause_d = C_TIMEOUT;
                    end
                end else begin
                    state_d = S_DO;
                end
            end
            S_DO: begin
                state_d   = halt ? S_HALT : S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_TRAP: begin
                if (go) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase

        if (state_q == S_FETCH && !wait_instr && !instr_segv) begin
            instr_word_d = instruction;
        end

        if (fetch_done) begin
            pc_d = instr_pc;
            ld_d = ld_req;
            st_d = st_req;
        end

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_HALT;
            instr_word_q <= '0;
            cause_q      <= '0;
            retired_q    <= '0;
            wait_cnt_q   <= '0;
            pc_q         <= 1'b0;
            ld_q         <= 1'b0;
            st_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_word_q <= instr_word_d;
            cause_q      <= cause_d;
            retired_q    <= retired_d;
            wait_cnt_q   <= wait_cnt_d;
            pc_q         <= pc_d;
            ld_q         <= ld_d;
            st_q         <= st_d;
        end
    end

    // Strobes decode from state and are forced low while reset is asserted.
    assign state      = state_q;
    assign instr_q    = instr_word_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;
    assign reg_write  = resetn && (state_q == S_DO);
    assign pc_inc     = resetn && (state_q == S_DO) && pc_q;
    assign ld         = resetn && (state_q == S_WAIT_LOAD);
    assign st         = resetn && (state_q == S_WAIT_STORE);
    assign trap       = resetn && (state_q == S_TRAP);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, ALU, load waits, timeout,
// faults, halt during store, reset mid-load and retired wrap (CNT_W=4).
module tb_control_sequencer;

    logic        clk;
    logic        resetn;
    logic        go;
    logic        halt;
    logic [31:0] instruction;
    logic        instr_segv;
    logic        data_segv;
    logic        wait_instr;
    logic        wait_data;
    logic        ld_req;
    logic        st_req;
    logic        instr_pc;
    logic        invalid_instruction;
    logic [31:0] instr_q;
    logic [2:0]  state;
    logic        pc_inc;
    logic        reg_write;
    logic        ld;
    logic        st;
    logic        trap;
    logic [2:0]  trap_cause;
    logic [3:0]  retired;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.INSTR_W(32), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .go                  (go),
        .halt                (halt),
        .instruction         (instruction),
        .instr_segv          (instr_segv),
        .data_segv           (data_segv),
        .wait_instr          (wait_instr),
        .wait_data           (wait_data),
        .ld_req              (ld_req),
        .st_req              (st_req),
        .instr_pc            (instr_pc),
        .invalid_instruction (invalid_instruction),
        .instr_q             (instr_q),
        .state               (state),
        .pc_inc              (pc_inc),
        .reg_write           (reg_write),
        .ld                  (ld),
        .st                  (st),
        .trap                (trap),
        .trap_cause          (trap_cause),
        .retired             (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        go = 0; halt = 0; instr_segv = 0; data_segv = 0;
        wait_instr = 0; wait_data = 0; ld_req = 0; st_req = 0;
        instr_pc = 0; invalid_instruction = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        instruction = 32'hDEAD_BEEF;
        resetn = 0;
        step();
        step();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if ({pc_inc, reg_write, ld, st, trap} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000",
                               {pc_inc, reg_write, ld, st, trap});
        end
        checks++;
        if (instr_q !== 32'd0 || trap_cause !== 3'd0 || retired !== 4'd0) begin
            errors++; $display("FAIL reset_regs instr_q=%h cause=%0d retired=%0d exp=0",
                               instr_q, trap_cause, retired);
        end
        resetn = 1;
        step();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL reset_idle got=%0d exp=0", state);
        end
    endtask

    task automatic test_alu();
        instruction = 32'h0000_1234;
        instr_pc = 1;
        go = 1;
        step();
        go = 0;
        checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL alu_fetch state got=%0d exp=1", state);
        end
        step();
        instr_pc = 0;
        instruction = 32'h5555_5555;
        checks++;
        if (state !== 3'd2 || reg_write !== 1'b1 || pc_inc !== 1'b1) begin
            errors++; $display("FAIL alu_do state=%0d rw=%b pc_inc=%b exp=2/1/1",
                               state, reg_write, pc_inc);
        end
        checks++;
        if (instr_q !== 32'h0000_1234) begin
            errors++; $display("FAIL alu_instr_q got=%h exp=00001234", instr_q);
        end
        halt = 1;
        step();
        halt = 0;
        checks++;
        if (state !== 3'd0 || retired !== 4'd1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL alu_done state=%0d retired=%0d rw=%b exp=0/1/0",
                               state, retired, reg_write);
        end
    endtask

    task automatic test_load_wait();
        int ld_cycles;
        instruction = 32'h0000_0003;
        ld_req = 1;
        go = 1;
        step();
        go = 0;
        step();
        ld_req = 0;
        ld_cycles = 0;
        wait_data = 1;
        for (int i = 0; i < 3; i++) begin
            if (ld) ld_cycles++;
            step();
        end
        wait_data = 0;
        if (ld) ld_cycles++;
        step();
        checks++;
        if (ld_cycles !== 4) begin
            errors++; $display("FAIL load_ld_cycles got=%0d exp=4", ld_cycles);
        end
        checks++;
        if (state !== 3'd2 || ld !== 1'b0 || pc_inc !== 1'b0) begin
            errors++; $display("FAIL load_do state=%0d ld=%b pc_inc=%b exp=2/0/0",
                               state, ld, pc_inc);
        end
        halt = 1;
        step();
        halt = 0;
        checks++;
        if (retired !== 4'd2) begin
            errors++; $display("FAIL load_retired got=%0d exp=2", retired);
        end
    endtask

    task automatic test_timeout();
        int stay;
        ld_req = 1;
        go = 1;
        step();
        go = 0;
        step();
        ld_req = 0;
        wait_data = 1;
        stay = 0;
        for (int i = 0; i < 15; i++) begin
            if (state == 3'd3) stay++;
            step();
        end
        checks++;
        if (stay !== 15) begin
            errors++; $display("FAIL timeout_wait_cycles got=%0d exp=15", stay);
        end
        checks++;
        if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 3'd4) begin
            errors++; $display("FAIL timeout_trap state=%0d trap=%b cause=%0d exp=5/1/4",
                               state, trap, trap_cause);
        end
        wait_data = 0;
        step();
        checks++;
        if (state !== 3'd5) begin
            errors++; $display("FAIL timeout_hold state=%0d exp=5", state);
        end
        go = 1;
        step();
        go = 0;
        checks++;
        if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 3'd4) begin
            errors++; $display("FAIL timeout_ack state=%0d trap=%b cause=%0d exp=0/0/4",
                               state, trap, trap_cause);
        end
    endtask

    task automatic test_faults();
        logic [31:0] held;
        held = instr_q;
        go = 1;
        step();
        go = 0;
        instruction = 32'hAAAA_0001;
        instr_segv = 1;
        wait_instr = 1;
        step();
        instr_segv = 0;
        wait_instr = 0;
        checks++;
        if (state !== 3'd5 || trap_cause !== 3'd1 || instr_q !== held) begin
            errors++; $display("FAIL isegv state=%0d cause=%0d instr_q=%h exp=5/1/%h",
                               state, trap_cause, instr_q, held);
        end
        go = 1;
        step();
        step();
        go = 0;
        ld_req = 1;
        st_req = 1;
        instruction = 32'h0000_00BB;
        step();
        ld_req = 0;
        st_req = 0;
        checks++;
        if (state !== 3'd5 || trap_cause !== 3'd3 || instr_q !== 32'h0000_00BB) begin
            errors++; $display("FAIL ldst_both state=%0d cause=%0d instr_q=%h exp=5/3/000000bb",
                               state, trap_cause, instr_q);
        end
        go = 1;
        step();
        go = 0;
    endtask

    task automatic test_halt_store();
        go = 1;
        st_req = 1;
        step();
        go = 0;
        step();
        st_req = 0;
        checks++;
        if (state !== 3'd4 || st !== 1'b1 || ld !== 1'b0) begin
            errors++; $display("FAIL store_wait state=%0d st=%b ld=%b exp=4/1/0",
                               state, st, ld);
        end
        halt = 1;
        wait_data = 1;
        step();
        wait_data = 0;
        checks++;
        if (state !== 3'd4) begin
            errors++; $display("FAIL store_halt_ignored state=%0d exp=4", state);
        end
        step();
        checks++;
        if (state !== 3'd2 || reg_write !== 1'b1) begin
            errors++; $display("FAIL store_do state=%0d rw=%b exp=2/1", state, reg_write);
        end
        step();
        halt = 0;
        checks++;
        if (state !== 3'd0 || retired !== 4'd3) begin
            errors++; $display("FAIL store_halt state=%0d retired=%0d exp=0/3",
                               state, retired);
        end
    endtask

    task automatic test_reset_mid_load();
        go = 1;
        ld_req = 1;
        step();
        go = 0;
        step();
        ld_req = 0;
        wait_data = 1;
        step();
        checks++;
        if (state !== 3'd3 || ld !== 1'b1) begin
            errors++; $display("FAIL midload_pre state=%0d ld=%b exp=3/1", state, ld);
        end
        resetn = 0;
        #1;
        checks++;
        if (ld !== 1'b0) begin
            errors++; $display("FAIL midload_in_reset ld=%b exp=0", ld);
        end
        step();
        resetn = 1;
        wait_data = 0;
        checks++;
        if (state !== 3'd0 || trap_cause !== 3'd0 || retired !== 4'd0) begin
            errors++; $display("FAIL midload_reset state=%0d cause=%0d retired=%0d exp=0/0/0",
                               state, trap_cause, retired);
        end
        step();
        checks++;
        if (ld !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL midload_after ld=%b state=%0d exp=0/0", ld, state);
        end
    endtask

    task automatic test_back_to_back();
        int pattern_ok;
        instr_pc = 1;
        go = 1;
        step();
        go = 0;
        pattern_ok = 1;
        for (int i = 0; i < 15; i++) begin
            if (state != 3'd1) pattern_ok = 0;
            step();
            if (state != 3'd2) pattern_ok = 0;
            step();
        end
        checks++;
        if (pattern_ok !== 1 || retired !== 4'd15) begin
            errors++; $display("FAIL b2b_run ok=%0d retired=%0d exp=1/15",
                               pattern_ok, retired);
        end
        step();
        step();
        checks++;
        if (retired !== 4'd0) begin
            errors++; $display("FAIL wrap_zero got=%0d exp=0", retired);
        end
        step();
        halt = 1;
        step();
        halt = 0;
        checks++;
        if (retired !== 4'd1 || state !== 3'd0) begin
            errors++; $display("FAIL wrap_one retired=%0d state=%0d exp=1/0",
                               retired, state);
        end
        instr_pc = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_timeout();
        test_faults();
        test_halt_store();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
